// File: rtl/spw_link_fsm.sv
// ============================================================================
// spw_link_fsm
// ----------------------------------------------------------------------------
// SpaceWire link-interface state machine. Walks the receiver and transmitter
// through ErrorReset, ErrorWait, Ready, Started, Connecting and Run. It owns
// the shared state timer (6.4us / 12.8us timeouts) and the disconnect
// detector, and drives the receiver reset and transmitter mode controls.
// It sits between the RX_SPW/TX blocks and the host register interface.
//
// Parameters
//   T_6U4   : pclk cycles spent in ErrorReset (6.4us)
//   T_12U8  : pclk cycles for the ErrorWait / Started / Connecting timeout
//   T_DISC  : pclk cycles without a received bit that mean a disconnect
//   TW      : timer width, must hold T_12U8-1
//
// Ports
//   pclk              in   system clock
//   reset             in   synchronous active-high reset
//   link_start        in   host requests link start (level)
//   auto_start        in   start on first received NULL (level)
//   link_disable      in   force link down (level)
//   rx_got_bit        in   receiver sampled a bit (pulse)
//   rx_got_null       in   NULL received (pulse)
//   rx_got_fct        in   FCT received (pulse)
//   rx_got_nchar      in   N-char received (pulse)
//   rx_got_time_code  in   time-code received (pulse)
//   rx_error          in   parity error (pulse)
//   esc_error         in   illegal ESC sequence (pulse)
//   credit_error      in   TX credit overflow (pulse)
//   rx_resetn         out  active-low receiver reset
//   tx_enable         out  transmitter active (sending NULLs)
//   tx_send_fct       out  transmitter may send FCTs
//   link_running      out  state is Run
//   link_state        out  0 ErrRst,1 ErrWait,2 Ready,3 Started,4 Connecting,5 Run
//   link_error        out  one-cycle pulse on an error-driven move to ErrRst
//   err_cause         out  1 disc,2 parity,3 esc,4 char_seq,5 credit,6 timeout
// ============================================================================
module spw_link_fsm #(
    parameter int T_6U4  = 640,
    parameter int T_12U8 = 1280,
    parameter int T_DISC = 85,
    parameter int TW     = 11
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       link_start,
    input  logic       auto_start,
    input  logic       link_disable,
    input  logic       rx_got_bit,
    input  logic       rx_got_null,
    input  logic       rx_got_fct,
    input  logic       rx_got_nchar,
    input  logic       rx_got_time_code,
    input  logic       rx_error,
    input  logic       esc_error,
    input  logic       credit_error,
    output logic       rx_resetn,
    output logic       tx_enable,
    output logic       tx_send_fct,
    output logic       link_running,
    output logic [2:0] link_state,
    output logic       link_error,
    output logic [2:0] err_cause
);

    typedef enum logic [2:0] {
        S_ERR_RST    = 3'd0,
        S_ERR_WAIT   = 3'd1,
        S_READY      = 3'd2,
        S_STARTED    = 3'd3,
        S_CONNECTING = 3'd4,
        S_RUN        = 3'd5
    } link_state_t;

    localparam int DW = $clog2(T_DISC + 1);

    localparam logic [TW-1:0] T6_LAST   = TW'(T_6U4 - 1);
    localparam logic [TW-1:0] T12_LAST  = TW'(T_12U8 - 1);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
    localparam logic [DW-1:0] DISC_LAST = DW'(T_DISC - 1);

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_DISC     = 3'd1;
    localparam logic [2:0] CAUSE_PARITY   = 3'd2;
    localparam logic [2:0] CAUSE_ESC      = 3'd3;
    localparam logic [2:0] CAUSE_CHAR_SEQ = 3'd4;
    localparam logic [2:0] CAUSE_CREDIT   = 3'd5;
    localparam logic [2:0] CAUSE_TIMEOUT  = 3'd6;

    link_state_t     state_r;
    link_state_t     state_next_s;
    logic [TW-1:0]   timer_r;
    logic [DW-1:0]   disc_cnt_r;
    logic            disc_armed_r;
    logic            got_null_seen_r;
    logic            null_seen_s;
    logic            disc_hit_s;
    logic            char_seq_s;
    logic            credit_s;
    logic            timeout_s;
    logic            enabled_s;
    logic [2:0]      fault_s;
    logic            err_move_s;
    logic [2:0]      cause_next_s;

    // Error qualification and cause priority for the current cycle.
    always_comb begin
        null_seen_s = 1'b0;
        disc_hit_s  = 1'b0;
        char_seq_s  = 1'b0;
        credit_s    = 1'b0;
        timeout_s   = 1'b0;
        enabled_s   = 1'b0;
        fault_s     = CAUSE_NONE;

        // A NULL arriving this cycle already counts as seen, so a Started
        // state advancing on that NULL sees a consistent flag.
        null_seen_s = got_null_seen_r | rx_got_null;
        disc_hit_s  = disc_armed_r & (disc_cnt_r == DISC_LAST);
        timeout_s   = (timer_r == T12_LAST);
        enabled_s   = ~link_disable & (link_start | (auto_start & null_seen_s));
        credit_s    = (state_r == S_RUN) & credit_error;

        if ((state_r == S_ERR_WAIT) || (state_r == S_READY) || (state_r == S_STARTED)) begin
            char_seq_s = null_seen_s & (rx_got_fct | rx_got_nchar | rx_got_time_code);
        end else if (state_r == S_CONNECTING) begin
            char_seq_s = rx_got_nchar | rx_got_time_code;
        end else begin
            char_seq_s = 1'b0;
        end

        if (disc_hit_s) begin
            fault_s = CAUSE_DISC;
        end else if (rx_error) begin
            fault_s = CAUSE_PARITY;
        end else if (esc_error) begin
            fault_s = CAUSE_ESC;
        end else if (char_seq_s) begin
            fault_s = CAUSE_CHAR_SEQ;
        end else if (credit_s) begin
            fault_s = CAUSE_CREDIT;
        end else begin
            fault_s = CAUSE_NONE;
        end
    end

    // Next-state logic: errors first, then timeouts, then forward moves.
    always_comb begin
        state_next_s = state_r;
        err_move_s   = 1'b0;
        cause_next_s = CAUSE_NONE;

        case (state_r)
            S_ERR_RST: begin
                if (timer_r == T6_LAST) begin
                    state_next_s = S_ERR_WAIT;
                end else begin
                    state_next_s = S_ERR_RST;
                end
            end
            S_ERR_WAIT: begin
                if (fault_s != CAUSE_NONE) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = fault_s;
                end else if (timeout_s) begin
                    state_next_s = S_READY;
                end else begin
                    state_next_s = S_ERR_WAIT;
                end
            end
            S_READY: begin
                if (fault_s != CAUSE_NONE) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = fault_s;
                end else if (enabled_s) begin
                    state_next_s = S_STARTED;
                end else begin
                    state_next_s = S_READY;
                end
            end
            S_STARTED: begin
                if (fault_s != CAUSE_NONE) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = fault_s;
                end else if (timeout_s) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = CAUSE_TIMEOUT;
                end else if (rx_got_null) begin
                    state_next_s = S_CONNECTING;
                end else begin
                    state_next_s = S_STARTED;
                end
            end
            S_CONNECTING: begin
                if (fault_s != CAUSE_NONE) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = fault_s;
                end else if (timeout_s) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = CAUSE_TIMEOUT;
                end else if (rx_got_fct) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_CONNECTING;
                end
            end
            S_RUN: begin
                if (fault_s != CAUSE_NONE) begin
                    state_next_s = S_ERR_RST;
                    err_move_s   = 1'b1;
                    cause_next_s = fault_s;
                end else if (link_disable) begin
                    // Host-requested shutdown is not an error.
                    state_next_s = S_ERR_RST;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                // Illegal encodings recover silently.
                state_next_s = S_ERR_RST;
            end
        endcase
    end

    // State register and registered state-derived outputs.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_r      <= S_ERR_RST;
            rx_resetn    <= 1'b0;
            tx_enable    <= 1'b0;
            tx_send_fct  <= 1'b0;
            link_running <= 1'b0;
            link_error   <= 1'b0;
            err_cause    <= CAUSE_NONE;
        end else begin
            state_r      <= state_next_s;
            rx_resetn    <= (state_next_s != S_ERR_RST);
            tx_enable    <= (state_next_s == S_STARTED) || (state_next_s == S_CONNECTING) ||
                            (state_next_s == S_RUN);
            tx_send_fct  <= (state_next_s == S_CONNECTING) || (state_next_s == S_RUN);
            link_running <= (state_next_s == S_RUN);
            link_error   <= err_move_s;
            if (err_move_s) begin
                err_cause <= cause_next_s;
            end else begin
                err_cause <= err_cause;
            end
        end
    end

    // Shared state timer: restarts on every state change, saturates otherwise.
    always_ff @(posedge pclk) begin
        if (reset) begin
            timer_r <= {TW{1'b0}};
        end else if (state_next_s != state_r) begin
            timer_r <= {TW{1'b0}};
        end else if (timer_r != TIMER_MAX) begin
            timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            timer_r <= timer_r;
        end
    end

    // Disconnect detector: armed by the first bit outside ErrRst.
    always_ff @(posedge pclk) begin
        if (reset || (state_r == S_ERR_RST)) begin
            disc_cnt_r   <= {DW{1'b0}};
            disc_armed_r <= 1'b0;
        end else if (rx_got_bit) begin
            disc_cnt_r   <= {DW{1'b0}};
            disc_armed_r <= 1'b1;
        end else if (disc_armed_r && (disc_cnt_r != DISC_LAST)) begin
            disc_cnt_r   <= disc_cnt_r + {{(DW-1){1'b0}}, 1'b1};
            disc_armed_r <= disc_armed_r;
        end else begin
            disc_cnt_r   <= disc_cnt_r;
            disc_armed_r <= disc_armed_r;
        end
    end

    // NULL-seen flag, cleared while in ErrRst.
    always_ff @(posedge pclk) begin
        if (reset || (state_r == S_ERR_RST)) begin
            got_null_seen_r <= 1'b0;
        end else if (rx_got_null) begin
            got_null_seen_r <= 1'b1;
        end else begin
            got_null_seen_r <= got_null_seen_r;
        end
    end

    assign link_state = state_r;

endmodule

// File: tb/tb_spw_link_fsm.sv
// ============================================================================
// tb_spw_link_fsm
// ----------------------------------------------------------------------------
// Directed testbench for spw_link_fsm. Inputs change 1ns after each rising
// edge and outputs are sampled at the same point, so every value seen
// reflects the registers updated by the preceding edge.
// ============================================================================
module tb_spw_link_fsm;

    logic       pclk = 1'b0;
    logic       reset;
    logic       link_start;
    logic       auto_start;
    logic       link_disable;
    logic       rx_got_bit;
    logic       rx_got_null;
    logic       rx_got_fct;
    logic       rx_got_nchar;
    logic       rx_got_time_code;
    logic       rx_error;
    logic       esc_error;
    logic       credit_error;
    logic       rx_resetn;
    logic       tx_enable;
    logic       tx_send_fct;
    logic       link_running;
    logic [2:0] link_state;
    logic       link_error;
    logic [2:0] err_cause;

    int n_compared   = 0;
    int n_mismatched = 0;

    spw_link_fsm dut (
        .pclk             (pclk),
        .reset            (reset),
        .link_start       (link_start),
        .auto_start       (auto_start),
        .link_disable     (link_disable),
        .rx_got_bit       (rx_got_bit),
        .rx_got_null      (rx_got_null),
        .rx_got_fct       (rx_got_fct),
        .rx_got_nchar     (rx_got_nchar),
        .rx_got_time_code (rx_got_time_code),
        .rx_error         (rx_error),
        .esc_error        (esc_error),
        .credit_error     (credit_error),
        .rx_resetn        (rx_resetn),
        .tx_enable        (tx_enable),
        .tx_send_fct      (tx_send_fct),
        .link_running     (link_running),
        .link_state       (link_state),
        .link_error       (link_error),
        .err_cause        (err_cause)
    );

    // 100 MHz clock.
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for a given state.
    task automatic wait_state(input logic [2:0] target, input string tag);
        int budget;
        budget = 4000;
        while ((link_state != target) && (budget > 0)) begin
            tick();
            budget--;
        end
        check(tag, link_state, target);
    endtask

    // From Ready, bring the link up to Run using link_start, NULL, FCT.
    task automatic run_up(input string tag);
        link_start = 1'b1;
        tick();
        link_start = 1'b0;
        check({tag, "_started"}, link_state, 3'd3);
        rx_got_null = 1'b1;
        tick();
        rx_got_null = 1'b0;
        check({tag, "_connecting"}, link_state, 3'd4);
        rx_got_fct = 1'b1;
        tick();
        rx_got_fct = 1'b0;
        check({tag, "_run"}, link_state, 3'd5);
    endtask

    initial begin
        reset = 1'b1;
        link_start = 1'b0; auto_start = 1'b0; link_disable = 1'b0;
        rx_got_bit = 1'b0; rx_got_null = 1'b0; rx_got_fct = 1'b0;
        rx_got_nchar = 1'b0; rx_got_time_code = 1'b0;
        rx_error = 1'b0; esc_error = 1'b0; credit_error = 1'b0;
        tick_n(3);

        // Reset state.
        check("rst_state",     link_state, 3'd0);
        check("rst_rx_resetn", rx_resetn, 1'b0);
        check("rst_tx_enable", tx_enable, 1'b0);
        check("rst_link_err",  link_error, 1'b0);
        check("rst_err_cause", err_cause, 3'd0);
        reset = 1'b0;

        // 1: 640 cycles in ErrRst, 1280 in ErrWait, then Ready.
        tick_n(639);
        check("t1_errrst_639",  link_state, 3'd0);
        check("t1_resetn_639",  rx_resetn, 1'b0);
        tick();
        check("t1_errwait_640", link_state, 3'd1);
        check("t1_resetn_640",  rx_resetn, 1'b1);
        check("t1_txen_wait",   tx_enable, 1'b0);
        tick_n(1279);
        check("t1_errwait_end", link_state, 3'd1);
        tick();
        check("t1_ready",       link_state, 3'd2);

        // 2: link_start -> Started -> Connecting -> Run.
        run_up("t2");
        check("t2_running",  link_running, 1'b1);
        check("t2_send_fct", tx_send_fct, 1'b1);
        check("t2_tx_en",    tx_enable, 1'b1);

        // 4: bits every 10 cycles, then silence -> disconnect 85 cycles later.
        for (int b = 0; b < 4; b++) begin
            rx_got_bit = 1'b1;
            tick();
            rx_got_bit = 1'b0;
            tick_n(9);
        end
        check("t4_run_with_bits", link_state, 3'd5);
        rx_got_bit = 1'b1;
        tick();
        rx_got_bit = 1'b0;
        tick_n(84);
        check("t4_still_run_84", link_state, 3'd5);
        tick();
        check("t4_disc_state", link_state, 3'd0);
        check("t4_disc_err",   link_error, 1'b1);
        check("t4_disc_cause", err_cause, 3'd1);
        check("t4_resetn",     rx_resetn, 1'b0);
        tick();
        check("t4_err_pulse_end", link_error, 1'b0);

        // 5: parity and credit together -> parity wins.
        wait_state(3'd2, "t5_ready");
        run_up("t5");
        rx_error = 1'b1;
        credit_error = 1'b1;
        tick();
        rx_error = 1'b0;
        credit_error = 1'b0;
        check("t5_state",   link_state, 3'd0);
        check("t5_cause",   err_cause, 3'd2);
        check("t5_err",     link_error, 1'b1);
        check("t5_resetn",  rx_resetn, 1'b0);
        check("t5_running", link_running, 1'b0);

        // 3: Started with no NULL times out after 1280 cycles.
        wait_state(3'd2, "t3_ready");
        link_start = 1'b1;
        tick();
        link_start = 1'b0;
        check("t3_started", link_state, 3'd3);
        tick_n(1279);
        check("t3_started_end", link_state, 3'd3);
        check("t3_no_err_yet",  link_error, 1'b0);
        tick();
        check("t3_timeout_state", link_state, 3'd0);
        check("t3_timeout_err",   link_error, 1'b1);
        check("t3_timeout_cause", err_cause, 3'd6);
        tick();
        check("t3_err_once",      link_error, 1'b0);
        check("t3_cause_hold",    err_cause, 3'd6);

        // 6a: auto_start with a NULL seen in ErrWait -> one cycle of Ready.
        auto_start = 1'b1;
        wait_state(3'd1, "t6_errwait");
        rx_got_null = 1'b1;
        tick();
        rx_got_null = 1'b0;
        wait_state(3'd2, "t6_ready");
        tick();
        check("t6_auto_started", link_state, 3'd3);

        // 6b: FCT during the Ready cycle after a NULL -> char_seq error.
        wait_state(3'd0, "t6_back_errrst");
        wait_state(3'd1, "t6_errwait2");
        rx_got_null = 1'b1;
        tick();
        rx_got_null = 1'b0;
        wait_state(3'd2, "t6_ready2");
        rx_got_fct = 1'b1;
        tick();
        rx_got_fct = 1'b0;
        check("t6_seq_state", link_state, 3'd0);
        check("t6_seq_cause", err_cause, 3'd4);
        check("t6_seq_err",   link_error, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
